voice_scheduler: RTL

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// voice_scheduler -- 8-step, 4-voice gate sequencer with a saturating mixer.
// Optional macro: VOICE_SCHEDULER_CHOKE_EN (voices 2 and 3 choke each other).
// Revision: 1.0
// ============================================================================
module voice_scheduler #(
  parameter int GATE_LEN = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic [31:0] pattern,
  input  logic [3:0]  raw_trig,
  input  logic [7:0]  smpl_in0,
  input  logic [7:0]  smpl_in1,
  input  logic [7:0]  smpl_in2,
  input  logic [7:0]  smpl_in3,
  output logic [3:0]  voice_en,
  output logic [2:0]  step_idx,
  output logic [7:0]  mix_out
);

  localparam logic [1:0]  MODE_PLAY = 2'd1;
  localparam logic [1:0]  MODE_RAW  = 2'd2;
  localparam logic [11:0] GATE_LOAD = 12'(GATE_LEN - 1);

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_GAP = 2'd1,
    ST_ON  = 2'd2
  } gate_state_t;

  logic       in_play;
  logic       is_play;
  logic       is_raw;
  logic       play_entry;
  logic       force_off;
  logic [3:0] step_trig;
  logic [3:0] trig;
  logic [3:0] choke;
  logic [9:0] mix_sum;

  assign is_play    = (mode == MODE_PLAY);
  assign is_raw     = (mode == MODE_RAW);
  assign play_entry = is_play && !in_play;
  // EDIT (modes 0 and 3) holds every voice off; leaving PLAY kills running gates.
  assign force_off  = (!is_play && !is_raw) || (in_play && !is_play);
  assign step_trig  = pattern[{step_idx, 2'b00} +: 4];

  always_comb begin
    trig = 4'h0;
    if (is_raw)
      trig = raw_trig;
    else if (is_play && !play_entry && tick)
      trig = step_trig;
  end

`ifdef VOICE_SCHEDULER_CHOKE_EN
  // Voice 3 wins a simultaneous trigger of the pair.
  assign choke = {trig[2] & ~trig[3], trig[3], 2'b00};
`else
  assign choke = 4'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_play  <= 1'b0;
      step_idx <= 3'd0;
    end else begin
      in_play <= is_play;
      if (play_entry)
        step_idx <= 3'd0;
      else if (is_play && tick)
        step_idx <= step_idx + 3'd1;
    end
  end

  for (genvar v = 0; v < 4; v++) begin : g_voice
    gate_state_t state;
    logic [11:0] cnt;
    logic        en;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_OFF;
        cnt   <= 12'd0;
        en    <= 1'b0;
      end else if (force_off || choke[v]) begin
        state <= ST_OFF;
        cnt   <= 12'd0;
        en    <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            if (trig[v]) begin
              state <= ST_ON;
              cnt   <= GATE_LOAD;
              en    <= 1'b1;
            end
          end
          ST_GAP: begin
            state <= ST_ON;
            cnt   <= GATE_LOAD;
            en    <= 1'b1;
          end
          ST_ON: begin
            // A retrigger beats expiry so the player always restarts cleanly.
            if (trig[v]) begin
              state <= ST_GAP;
              en    <= 1'b0;
            end else if (cnt == 12'd0) begin
              state <= ST_OFF;
              en    <= 1'b0;
            end else begin
              cnt <= cnt - 12'd1;
            end
          end
          default: begin
            state <= ST_OFF;
            cnt   <= 12'd0;
            en    <= 1'b0;
          end
        endcase
      end
    end

    assign voice_en[v] = en;
  end

  always_comb begin
    mix_sum = 10'd0;
    if (voice_en[0]) mix_sum = mix_sum + {2'b00, smpl_in0};
    if (voice_en[1]) mix_sum = mix_sum + {2'b00, smpl_in1};
    if (voice_en[2]) mix_sum = mix_sum + {2'b00, smpl_in2};
    if (voice_en[3]) mix_sum = mix_sum + {2'b00, smpl_in3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mix_out <= 8'h00;
    else
      mix_out <= (mix_sum > 10'd255) ? 8'hFF : mix_sum[7:0];
  end

endmodule
`default_nettype wire
